afficheur_compteur_bcd: RTL

Display-side reader for the 12-bit signed up/down counter value. On request, it samples the two's-complement count and converts its magnitude to four BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives five active-low 7-segment displays (sign plus four digits) with leading-zero blanking. It sits between the counter output bus and the board's HEX displays and holds the last converted value until the next request.

---
 rtl/afficheur_pkg.sv | 32 +++
 rtl/dec_bcd_7seg.sv | 37 +++
 rtl/afficheur_compteur_bcd.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/afficheur_pkg.sv
// ---------------------------------------------------------------------------
// afficheur_pkg
// Shared definitions for the BCD display reader:
//   - state_e    : conversion FSM states (IDLE / SHIFT / DONE)
//   - SEG_BLANK  : all segments off (active-low)
//   - SEG_MINUS  : only segment g lit, used for the sign display
//   - SEG_ZERO   : digit "0" pattern, reset value of the units display
//   - add3_ge5   : one double-dabble correction step on a single BCD digit
// ---------------------------------------------------------------------------
package afficheur_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // A digit of 5 or more would become >= 10 after the next doubling,
    // so it is pre-corrected by +3 to carry cleanly into the next digit.
    function automatic logic [3:0] add3_ge5(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end
        return d;
    endfunction

endpackage

// File: rtl/dec_bcd_7seg.sv
// ---------------------------------------------------------------------------
// dec_bcd_7seg
// Combinational BCD digit to active-low 7-segment decoder.
// Ports:
//   bcd_i   [3:0] : BCD digit code (0..9 meaningful)
//   blank_i       : 1 forces the display dark (leading-zero blanking)
//   seg_o   [6:0] : segments {g,f,e,d,c,b,a}, active-low
// Codes 10..15 cannot be produced by the converter and decode to blank.
// ---------------------------------------------------------------------------
module dec_bcd_7seg
    import afficheur_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_ZERO;
                4'd1:    seg_o = 7'b1111001;
                4'd2:    seg_o = 7'b0100100;
                4'd3:    seg_o = 7'b0110000;
                4'd4:    seg_o = 7'b0011001;
                4'd5:    seg_o = 7'b0010010;
                4'd6:    seg_o = 7'b0000010;
                4'd7:    seg_o = 7'b1111000;
                4'd8:    seg_o = 7'b0000000;
                4'd9:    seg_o = 7'b0010000;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/afficheur_compteur_bcd.sv
// ---------------------------------------------------------------------------
// afficheur_compteur_bcd
// Samples a signed two's-complement count on request, converts its magnitude
// to DIGITS BCD digits with an iterative shift-add-3 engine (one bit per
// cycle), and drives four digit displays plus one sign display, all
// active-low, with leading-zero blanking. The last result is held until the
// next conversion completes, so the displays never show partial values.
//
// Ports:
//   clock_i          : rising-edge clock
//   reset_i          : asynchronous active-high reset, clears all state
//   start_i          : conversion request, accepted only while idle
//   valeur_i [W-1:0] : signed value, sampled in the accepting cycle only
//   busy_o           : high from acceptance until the result edge
//   done_o           : one-cycle pulse with each new result
//   signe_o          : 1 when the last converted value was negative
//   bcd_o   [4D-1:0] : packed digits, most significant digit at the top
//   hex0_o..hex3_o   : digit displays, units..thousands
//   hex4_o           : sign display (minus or blank)
//
// Timing: start accepted at edge k, shifts at k+1..k+WIDTH, result and
// done pulse at edge k+WIDTH+1.
// ---------------------------------------------------------------------------
module afficheur_compteur_bcd
    import afficheur_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      valeur_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  signe_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [6:0]            hex0_o,
    output logic [6:0]            hex1_o,
    output logic [6:0]            hex2_o,
    output logic [6:0]            hex3_o,
    output logic [6:0]            hex4_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               signe_q, signe_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            signe_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            signe_q   <= signe_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        signe_d   = signe_q;
        done_d    = 1'b0;

        // Per-digit +3 correction applied before every shift.
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = add3_ge5(scratch_q[4*i +: 4]);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Magnitude fits in WIDTH unsigned bits, so the most
                    // negative input maps to 2^(WIDTH-1) without overflow.
                    if (valeur_i[WIDTH-1]) begin
                        mag_d = ~valeur_i + WIDTH'(1);
                    end else begin
                        mag_d = valeur_i;
                    end
                    neg_d     = valeur_i[WIDTH-1];
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                {scratch_d, mag_d} = {adj, mag_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                bcd_d   = scratch_q;
                signe_d = neg_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign signe_o = signe_q;
    assign bcd_o   = bcd_q;

    // ------------------------------------------------------------------
    // Display decode from the registered result only
    // ------------------------------------------------------------------
    // A digit is blanked when it and every more significant digit are zero;
    // the units digit always shows.
    logic [DIGITS-1:0] blank;

    always_comb begin
        blank = '0;
        if (DIGITS > 1) begin
            blank[DIGITS-1] = (bcd_q[4*(DIGITS-1) +: 4] == 4'd0);
            for (int i = DIGITS - 2; i >= 1; i--) begin
                blank[i] = blank[i+1] && (bcd_q[4*i +: 4] == 4'd0);
            end
        end
    end

    logic [6:0] seg [DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        dec_bcd_7seg u_dec (
            .bcd_i   (bcd_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg[g])
        );
    end

    assign hex0_o = seg[0];
    assign hex1_o = seg[1];
    assign hex2_o = seg[2];
    assign hex3_o = seg[3];
    // Minus sign always sits on the leftmost display.
    assign hex4_o = signe_q ? SEG_MINUS : SEG_BLANK;

endmodule
